// File: rtl/pit_irq_collector_pkg.sv
// Shared types and helpers for the interrupt collector.
//   state_t   : presentation FSM state (IDLE / PRESENT), 1 bit
//   calc_idw  : source-ID width for a given number of sources, minimum 1
//   popcount8 : number of set bits in an 8-bit vector
//   sat_add   : unsigned add clamped to 2^w - 1
package pit_irq_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  function automatic int calc_idw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) s = s + {3'b000, v[i]};
    return s;
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int          w);
    logic [31:0] lim;
    logic [32:0] sum;
    lim = (32'd1 << w) - 32'd1;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, lim}) ? lim : sum[31:0];
  endfunction

endpackage

// File: rtl/pit_irq_collector_if.sv
// Presentation handshake between the collector and its consumer.
//   irq_valid : a source is being presented (collector -> consumer)
//   irq_id    : index of the presented source, stable while irq_valid
//   irq_ack   : consumer accepts the presented source (consumer -> collector)
// The collector connects through the master modport, the consumer through slave.
interface pit_irq_if
  import pit_irq_pkg::*;
#(
  parameter int IDW = calc_idw(4)
) ();
  logic           irq_valid;
  logic [IDW-1:0] irq_id;
  logic           irq_ack;

  modport master (output irq_valid, output irq_id, input irq_ack);
  modport slave  (input irq_valid, input irq_id, output irq_ack);
endinterface

// File: rtl/pit_irq_collector_prio_enc.sv
// Fixed-priority encoder: the lowest set request index wins.
//   i_req : request vector
//   o_any : at least one request is set
//   o_idx : index of the winning request (0 when none is set)
module pit_irq_prio_enc
  import pit_irq_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int IDW     = calc_idw(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] i_req,
  output logic               o_any,
  output logic [IDW-1:0]     o_idx
);

  always_comb begin
    o_any = |i_req;
    o_idx = '0;
    // Scan downwards so the last assignment made is the lowest set index.
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (i_req[i]) o_idx = IDW'(i);
    end
  end

endmodule

// File: rtl/pit_irq_collector.sv
// Interrupt collector: latches single-cycle interrupt pulses as pending,
// presents them one at a time by fixed priority (lowest index first) on a
// valid/ack handshake, and counts pulses that land on an already-pending source.
//   clk, rst        : clock, synchronous active-high reset
//   i_enable        : 0 ignores new edges; pending/handshake keep operating
//   i_irq_in        : raw interrupt lines
//   i_mask          : 1 = source may be presented (masked sources still latch)
//   i_overrun_clr   : synchronous clear of the overrun counter
//   o_pending       : raw pending register
//   o_overrun_cnt   : saturating overrun count
//   bus             : presentation handshake (irq_valid / irq_id / irq_ack)
module pit_irq_collector
  import pit_irq_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int CNT_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_enable,
  input  logic [NUM_SRC-1:0] i_irq_in,
  input  logic [NUM_SRC-1:0] i_mask,
  input  logic               i_overrun_clr,
  output logic [NUM_SRC-1:0] o_pending,
  output logic [CNT_W-1:0]   o_overrun_cnt,
  pit_irq_if.master          bus
);

  localparam int IDW = calc_idw(NUM_SRC);

  logic [NUM_SRC-1:0] r_prev_in;
  logic [NUM_SRC-1:0] r_pending;
  logic [CNT_W-1:0]   r_ovr_cnt;
  state_t             r_state;
  logic [IDW-1:0]     r_id;
  logic               r_valid;

  logic [NUM_SRC-1:0] w_set;
  logic [NUM_SRC-1:0] w_ack_clr;
  logic [NUM_SRC-1:0] w_ovr;
  logic [NUM_SRC-1:0] w_pending_nxt;
  logic [CNT_W-1:0]   w_ovr_cnt_nxt;
  logic               w_any;
  logic [IDW-1:0]     w_idx;
  state_t             w_state_nxt;
  logic [IDW-1:0]     w_id_nxt;

  pit_irq_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .IDW     (IDW)
  ) u_prio (
    .i_req (r_pending & i_mask),
    .o_any (w_any),
    .o_idx (w_idx)
  );

  // Pending update: the ack clears its source, but a same-cycle new edge on
  // that source re-sets it. An overrun only counts when the source stays
  // pending without being cleared this cycle.
  always_comb begin
    w_set         = i_enable ? (i_irq_in & ~r_prev_in) : '0;
    w_ack_clr     = (r_state == PRESENT && bus.irq_ack) ? (NUM_SRC'(1) << r_id) : '0;
    w_ovr         = w_set & r_pending & ~w_ack_clr;
    w_pending_nxt = (r_pending & ~w_ack_clr) | w_set;
    if (i_overrun_clr) begin
      w_ovr_cnt_nxt = '0;
    end else begin
      w_ovr_cnt_nxt = CNT_W'(sat_add(32'(r_ovr_cnt), 32'(popcount8(8'(w_ovr))), CNT_W));
    end
  end

  // Presentation FSM: the ID is locked on leaving IDLE, so mask changes or
  // higher-priority arrivals never disturb a source being presented.
  always_comb begin
    w_state_nxt = r_state;
    w_id_nxt    = r_id;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = PRESENT;
          w_id_nxt    = w_idx;
        end
      end
      PRESENT: begin
        if (bus.irq_ack) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // All-ones so a line already high at reset release is not an edge.
      r_prev_in <= '1;
      r_pending <= '0;
      r_ovr_cnt <= '0;
      r_state   <= IDLE;
      r_id      <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_prev_in <= i_irq_in;
      r_pending <= w_pending_nxt;
      r_ovr_cnt <= w_ovr_cnt_nxt;
      r_state   <= w_state_nxt;
      r_id      <= w_id_nxt;
      r_valid   <= (w_state_nxt == PRESENT);
    end
  end

  assign o_pending     = r_pending;
  assign o_overrun_cnt = r_ovr_cnt;
  assign bus.irq_valid = r_valid;
  assign bus.irq_id    = r_id;

endmodule
